// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end: size encodings, FSM states,
// and the captured request payload.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_WR0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_cap_t;

  // Access width in bytes; the illegal size code is faulted elsewhere.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_nbytes = 3'd1;
      SZ_HALF: size_nbytes = 3'd2;
      default: size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane datapath: extracts/extends load data from a two-word window and
// merges store data into the two captured words.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_w0_o,
  output logic [31:0] st_w1_o
);

  logic [63:0] window;
  logic [63:0] shifted;
  logic [63:0] st_data;
  logic [63:0] merged;
  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;

  always_comb begin : lane_logic
    window  = {w1_i, w0_i};
    shifted = window >> {off_i, 3'b000};
    st_data = 64'(wdata_i) << {off_i, 3'b000};

    case (size_i)
      SZ_BYTE: ld_data_o = unsigned_i ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data_o = unsigned_i ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data_o = shifted[31:0];
    endcase

    case (size_i)
      SZ_BYTE: base_mask = 8'h01;
      SZ_HALF: base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    lane_mask = base_mask << off_i;

    // Lanes outside the access keep the values read from RAM.
    merged = window;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) merged[8*i +: 8] = st_data[8*i +: 8];
    end
    st_w0_o = merged[31:0];
    st_w1_o = merged[63:32];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a single-port word RAM: word-granular reads and
// read-modify-write stores. Split (word-straddling) accesses are performed only
// when MAU_MISALIGNED_SPLIT_EN is defined; otherwise they fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              ram_write_en,
  output logic [AW-1:0]     ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [63:0]   BYTE_LIMIT = 64'(DEPTH) * 64'd4;
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  req_cap_t      cap_q, cap_d;
  logic [AW-1:0] idx0_q, idx0_d;
  logic          split_q, split_d;
  logic [31:0]   w0_q, w0_d, w1_q, w1_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_fault_q, rsp_fault_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;

  logic [1:0]    dec_off;
  logic [2:0]    dec_nb;
  logic [AW-1:0] dec_idx0;
  logic          dec_split;
  logic          dec_fault;

  logic [31:0]   ld_data, st_w0, st_w1;

  // Decode of the incoming request, used only on accept.
  always_comb begin : req_decode
    dec_off   = req_addr[1:0];
    dec_nb    = size_nbytes(req_size);
    dec_idx0  = req_addr[2 +: AW];
    dec_split = (3'(dec_off) + dec_nb) > 3'd4;
    dec_fault = (req_size == 2'd3) || (64'(req_addr) >= BYTE_LIMIT);
`ifdef MAU_MISALIGNED_SPLIT_EN
    if (dec_split && (dec_idx0 == LAST_IDX)) dec_fault = 1'b1;
`else
    if (dec_split) dec_fault = 1'b1;
`endif
  end

  // Read capture; the lane datapath sees the word being read this cycle.
  always_comb begin : word_capture
    w0_d = w0_q;
    w1_d = w1_q;
    if (state_q == ST_RD0) w0_d = ram_rdata;
`ifdef MAU_MISALIGNED_SPLIT_EN
    if (state_q == ST_RD1) w1_d = ram_rdata;
`endif
  end

  mem_byte_lane u_byte_lane (
    .w0_i       (w0_d),
    .w1_i       (w1_d),
    .off_i      (cap_q.off),
    .size_i     (cap_q.size),
    .unsigned_i (cap_q.is_unsigned),
    .wdata_i    (cap_q.wdata),
    .ld_data_o  (ld_data),
    .st_w0_o    (st_w0),
    .st_w1_o    (st_w1)
  );

`ifndef MAU_MISALIGNED_SPLIT_EN
  logic unused_split;
  assign unused_split = ^{split_q, st_w1};
`endif

  always_comb begin : fsm_next
    state_d     = state_q;
    cap_d       = cap_q;
    idx0_d      = idx0_q;
    split_d     = split_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          cap_d       = '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                          off: dec_off, wdata: req_wdata};
          idx0_d      = dec_idx0;
          split_d     = dec_split;
          req_ready_d = 1'b0;
          if (dec_fault) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_RD0;
            ram_addr_d  = dec_idx0;
            rsp_fault_d = 1'b0;
          end
        end
      end
      ST_RD0: begin
        if (cap_q.we) begin
          state_d     = ST_WR0;
          ram_we_d    = 1'b1;
          ram_wdata_d = st_w0;
        end
`ifdef MAU_MISALIGNED_SPLIT_EN
        else if (split_q) begin
          state_d    = ST_RD1;
          ram_addr_d = idx0_q + AW'(1);
        end
`endif
        else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_data;
        end
      end
      ST_WR0: begin
`ifdef MAU_MISALIGNED_SPLIT_EN
        if (split_q) begin
          state_d    = ST_RD1;
          ram_addr_d = idx0_q + AW'(1);
        end else
`endif
        begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
`ifdef MAU_MISALIGNED_SPLIT_EN
      ST_RD1: begin
        if (cap_q.we) begin
          state_d     = ST_WR1;
          ram_we_d    = 1'b1;
          ram_wdata_d = st_w1;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_data;
        end
      end
      ST_WR1: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
`endif
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_fault_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Async reset also drops ram_write_en at once, so no partial write commits.
  always_ff @(posedge clock or negedge reset_n) begin : fsm_regs
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      idx0_q      <= '0;
      split_q     <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      idx0_q      <= idx0_d;
      split_q     <= split_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_fault    = rsp_fault_q;
  assign ram_write_en = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word RAM and a
// byte-addressed reference memory; expectations follow MAU_MISALIGNED_SPLIT_EN.
module tb_mem_access_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          TMO   = 50;
`ifdef MAU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          writes;
  } exp_t;

  logic          clock, reset_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_fault;
  logic [31:0]   rsp_rdata;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          wr_cnt  = 0;
  int          txn_id  = 0;

  mem_access_unit #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural single-port RAM: combinational read, write on the rising edge.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_write_en) mem[ram_addr] <= ram_wdata;
  end
  always @(negedge clock) if (ram_write_en) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     <= 32'hA5A5_0000 | 32'(i);
      ref_mem[i]  = 32'hA5A5_0000 | 32'(i);
    end
    mem[0]     <= 32'h4433_2211;
    mem[1]     <= 32'h8877_6655;
    ref_mem[0]  = 32'h4433_2211;
    ref_mem[1]  = 32'h8877_6655;
    #1;
  endtask

  // Reference: byte-at-a-time access against ref_mem.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          nb;
    logic        split;
    logic [31:0] a;
    logic [31:0] v;
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    split = (int'(addr[1:0]) + nb) > 4;
    e.fault = (sz == 2'd3) || (addr >= 32'(DEPTH * 4)) ||
              (split && (!SPLIT_EN || addr[31:2] == 32'(DEPTH - 1)));
    e.rdata  = '0;
    e.lat    = 1;
    e.writes = 0;
    if (!e.fault) begin
      if (we) begin
        for (int i = 0; i < nb; i++) begin
          a = addr + 32'(i);
          ref_mem[a[AW+1:2]][8*a[1:0] +: 8] = wd[8*i +: 8];
        end
        e.lat    = split ? 5 : 3;
        e.writes = split ? 2 : 1;
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) begin
          a = addr + 32'(i);
          v = v | (32'(ref_mem[a[AW+1:2]][8*a[1:0] +: 8]) << (8 * i));
        end
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        e.rdata = v;
        e.lat   = split ? 3 : 2;
      end
    end
    return e;
  endfunction

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold);
    exp_t e;
    int   waited, start, wr0, lat, idx;
    txn_id++;
    waited = 0;
    while (!req_ready && waited < TMO) begin
      @(posedge clock); #1; waited++;
    end
    check($sformatf("t%0d_ready_timeout", txn_id), 32'(waited >= TMO), 32'd0);
    sb.push_back(model(we, sz, uns, addr, wd));
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    start = cyc;
    wr0   = wr_cnt;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    waited = 0;
    while (!rsp_valid && waited < TMO) begin
      @(posedge clock); #1; waited++;
    end
    check($sformatf("t%0d_rsp_timeout", txn_id), 32'(waited >= TMO), 32'd0);
    lat = cyc - start;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      check($sformatf("t%0d_hold_valid", txn_id), 32'(rsp_valid), 32'd1);
      check($sformatf("t%0d_hold_rdata", txn_id), rsp_rdata, sb[0].rdata);
      check($sformatf("t%0d_hold_fault", txn_id), 32'(rsp_fault), 32'(sb[0].fault));
      check($sformatf("t%0d_hold_req_ready", txn_id), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    e = sb.pop_front();
    check($sformatf("t%0d_rdata", txn_id), rsp_rdata, e.rdata);
    check($sformatf("t%0d_fault", txn_id), 32'(rsp_fault), 32'(e.fault));
    check($sformatf("t%0d_latency", txn_id), 32'(lat), 32'(e.lat));
    check($sformatf("t%0d_writes", txn_id), 32'(wr_cnt - wr0), 32'(e.writes));
    @(posedge clock); #1;
    check($sformatf("t%0d_rsp_drop", txn_id), 32'(rsp_valid), 32'd0);
    idx = int'(addr >> 2);
    for (int j = 0; j < 2; j++) begin
      if (addr < 32'(DEPTH * 4) && idx + j < int'(DEPTH))
        check($sformatf("t%0d_mem%0d", txn_id, idx + j), mem[idx + j], ref_mem[idx + j]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    preload();
    repeat (3) @(posedge clock);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_ram_we", 32'(ram_write_en), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    preload(); txn(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 0);
    check("plan_word0", rsp_rdata, 32'd0);
    preload(); txn(1'b0, 2'd0, 1'b0, 32'd7, 32'd0, 0);
    preload(); txn(1'b0, 2'd0, 1'b1, 32'd7, 32'd0, 0);
    preload(); txn(1'b1, 2'd1, 1'b0, 32'd2, 32'h0000_BEEF, 0);
    check("plan_store_half", mem[0], 32'hBEEF_2211);
    preload(); txn(1'b0, 2'd2, 1'b0, 32'd3, 32'd0, 0);
    preload(); txn(1'b1, 2'd2, 1'b0, 32'd3, 32'hDDCC_BBAA, 0);
    preload(); txn(1'b0, 2'd2, 1'b0, 32'(DEPTH * 4), 32'd0, 5);
    preload(); txn(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 5);
    preload(); txn(1'b0, 2'd1, 1'b1, 32'(DEPTH * 4 - 1), 32'd0, 0);
    preload(); txn(1'b1, 2'd2, 1'b0, 32'(DEPTH * 4 - 2), 32'h1234_5678, 0);
    preload(); txn(1'b0, 2'd1, 1'b0, 32'd5, 32'd0, 0);

    // Reset pulled during the WR0 cycle of a store.
    preload();
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'd2; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("wr0_we_high", 32'(ram_write_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_we_drop", 32'(ram_write_en), 32'd0);
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_mem0_kept", mem[0], ref_mem[0]);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    preload();
    for (int k = 0; k < 40; k++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, DEPTH * 4 + 7)), $urandom, (k % 7 == 3) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
